// File: rtl/inv_sub_bytes_engine.sv
// AES InvSubBytes engine: accepts one 128-bit state, substitutes LANES bytes per
// cycle through the inverse S-box, then presents the result over valid/ready.
module inv_sub_bytes_engine #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NCYC = 16 / LANES;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [127:0]   buf_q, buf_d;

  logic [4:0]     lane_idx [LANES];
  logic [7:0]     lane_out [LANES];

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); it also maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p;
    logic [7:0] r;
    p = x;
    r = 8'h01;
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_affine(input logic [7:0] x);
    return {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(inv_affine(x));
  endfunction

  // Byte 0 is the MSB, so byte i lives at bits [127-8i -: 8].
  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign lane_idx[gi] = 5'(int'(cnt_q) * LANES + gi);
    assign lane_out[gi] = inv_sbox(buf_q[127 - 8 * int'(lane_idx[gi]) -: 8]);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_data;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        for (int i = 0; i < LANES; i++) begin
          buf_d[127 - 8 * int'(lane_idx[i]) -: 8] = lane_out[i];
        end
        if (cnt_q == CW'(NCYC - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          buf_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = out_valid ? buf_q : 128'h0;

endmodule
